// File: rtl/loader_pkg.sv
// Shared types and constants for the framed RAM loader.
// State encoding, default sync marker and header length.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR_H,
    ADDR_L,
    LEN_H,
    LEN_L,
    DATA,
    CHK,
    RESP
  } state_e;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int         HDR_BYTES = 5;

endpackage

// File: rtl/ram_loader_if.sv
// Byte-stream in, RAM write port and status out.
// master: loader side; slave: UART/RAM/CPU side.
interface ram_loader_if #(
  parameter int addr_width = 12,
  parameter int data_width = 8
);
  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic [addr_width-1:0] w_addr;
  logic                  w_en;
  logic [data_width-1:0] din;
  logic                  busy;
  logic                  done;
  logic                  err;

  modport master (
    input  rx_data, rx_valid,
    output rx_ready, w_addr, w_en, din,
    output busy, done, err
  );

  modport slave (
    output rx_data, rx_valid,
    input  rx_ready, w_addr, w_en, din,
    input  busy, done, err
  );
endinterface

// File: rtl/ram_loader_timeout.sv
// Inter-byte idle counter for an open frame.
// clear/enable in; expired pulses on the cycle the count reaches LIMIT.
module ram_loader_timeout #(
  parameter int LIMIT = 65535
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear)
      cnt_d = '0;
    else if (enable)
      cnt_d = cnt_q + 16'd1;
  end

  // Fires on the idle cycle that brings the count to LIMIT,
  // so the FSM leaves the frame at that same edge.
  assign expired = enable && !clear &&
                   (cnt_q == 16'(LIMIT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/ram_loader.sv
// Parses sync/addr/len/payload/xor frames into RAM writes.
// Ports: clk, rst_n, bus (ram_loader_if.master).
module ram_loader
  import loader_pkg::*;
#(
  parameter int         addr_width     = 12,
  parameter int         data_width     = 8,
  parameter logic [7:0] sync_byte      = SYNC_BYTE,
  parameter int         timeout_cycles = 65535
) (
  input  logic          clk,
  input  logic          rst_n,
  ram_loader_if.master  bus
);

  localparam int AW = addr_width;
  localparam int DW = data_width;

  state_e        state_q, state_d;
  logic [7:0]    hi_q, hi_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [15:0]   len_q, len_d;
  logic [7:0]    csum_q, csum_d;
  logic          rx_ready_q, rx_ready_d;
  logic          w_en_q, w_en_d;
  logic [AW-1:0] w_addr_q, w_addr_d;
  logic [DW-1:0] din_q, din_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic          acc;
  logic          active;
  logic          to_exp;
  logic [7:0]    rx;

  assign rx     = bus.rx_data;
  assign acc    = bus.rx_valid && rx_ready_q;
  assign active = !(state_q inside {IDLE, RESP});

  ram_loader_timeout #(
    .LIMIT (timeout_cycles)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (!active || acc),
    .enable  (active && !acc),
    .expired (to_exp)
  );

  always_comb begin
    state_d  = state_q;
    hi_d     = hi_q;
    addr_d   = addr_q;
    len_d    = len_q;
    csum_d   = csum_q;
    w_en_d   = 1'b0;
    w_addr_d = w_addr_q;
    din_d    = din_q;
    done_d   = 1'b0;
    err_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (acc && rx == sync_byte) begin
          csum_d  = '0;
          state_d = ADDR_H;
        end
      end
      ADDR_H: begin
        if (acc) begin
          hi_d    = rx;
          state_d = ADDR_L;
        end
      end
      ADDR_L: begin
        if (acc) begin
          // High address bits beyond the RAM are dropped.
          addr_d  = AW'({hi_q, rx});
          state_d = LEN_H;
        end
      end
      LEN_H: begin
        if (acc) begin
          len_d[15:8] = rx;
          state_d     = LEN_L;
        end
      end
      LEN_L: begin
        if (acc) begin
          len_d[7:0] = rx;
          state_d    = (len_d == 16'd0) ? CHK : DATA;
        end
      end
      DATA: begin
        if (acc) begin
          w_en_d   = 1'b1;
          w_addr_d = addr_q;
          din_d    = DW'(rx);
          addr_d   = addr_q + AW'(1);
          len_d    = len_q - 16'd1;
          csum_d   = csum_q ^ rx;
          if (len_q == 16'd1)
            state_d = CHK;
        end
      end
      CHK: begin
        if (acc) begin
          done_d  = 1'b1;
          err_d   = (rx != csum_q);
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (to_exp) begin
      done_d  = 1'b1;
      err_d   = 1'b1;
      state_d = RESP;
    end

    rx_ready_d = (state_d != RESP);
    busy_d     = !(state_d inside {IDLE, RESP});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      hi_q       <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      csum_q     <= '0;
      rx_ready_q <= 1'b1;
      w_en_q     <= 1'b0;
      w_addr_q   <= '0;
      din_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      hi_q       <= hi_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      csum_q     <= csum_d;
      rx_ready_q <= rx_ready_d;
      w_en_q     <= w_en_d;
      w_addr_q   <= w_addr_d;
      din_q      <= din_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign bus.rx_ready = rx_ready_q;
  assign bus.w_en     = w_en_q;
  assign bus.w_addr   = w_addr_q;
  assign bus.din      = din_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_ram_loader.sv
// Directed bench for ram_loader: frame table plus
// timeout and mid-frame reset sequences.
module tb_ram_loader;
  import loader_pkg::*;

  localparam int AW = 12;
  localparam int DW = 8;
  localparam int TO = 40;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ram_loader_if #(
    .addr_width (AW),
    .data_width (DW)
  ) bus ();

  ram_loader #(
    .addr_width     (AW),
    .data_width     (DW),
    .sync_byte      (SYNC_BYTE),
    .timeout_cycles (TO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int off;
    int n;
    int woff;
    int nw;
    bit err;
  } vec_t;

  vec_t        tbl[5];
  logic [7:0]  stream[$];
  logic [19:0] exp_wr[$];

  logic [19:0] wq[$];
  int          wcyc[$];
  int          cyc = 0;
  int          done_n = 0;
  int          viol = 0;
  bit          last_err = 1'b0;
  int          n_chk = 0;
  int          n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.w_en) begin
      wq.push_back({bus.w_addr, bus.din});
      wcyc.push_back(cyc);
    end
    if (bus.done) begin
      done_n++;
      last_err = bus.err;
    end
    if (bus.err && !bus.done) viol++;
    if (bus.done && bus.w_en) viol++;
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic chk_reset_vals();
    chk("rst_rx_ready", 32'(bus.rx_ready), 1);
    chk("rst_w_en", 32'(bus.w_en), 0);
    chk("rst_w_addr", 32'(bus.w_addr), 0);
    chk("rst_din", 32'(bus.din), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_err", 32'(bus.err), 0);
  endtask

  task automatic clr();
    wq.delete();
    wcyc.delete();
    done_n = 0;
  endtask

  task automatic send(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int lim);
    for (int i = 0; i < lim && done_n == 0; i++)
      @(posedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input int k);
    vec_t v;
    v = tbl[k];
    clr();
    for (int i = 0; i < v.n; i++)
      send(stream[v.off + i]);
    bus.rx_valid = 1'b0;
    wait_done(60);
    chk("done_count", done_n, 1);
    chk("err_flag", 32'(last_err), 32'(v.err));
    chk("wr_count", wq.size(), v.nw);
    for (int j = 0; j < v.nw && j < wq.size(); j++) begin
      chk("wr_addr_data", 32'(wq[j]),
          32'(exp_wr[v.woff + j]));
      if (j > 0)
        chk("wr_gap", wcyc[j] - wcyc[j-1], 1);
    end
    @(posedge clk);
    #1;
    chk("busy_after", 32'(bus.busy), 0);
    chk("ready_after", 32'(bus.rx_ready), 1);
  endtask

  initial begin
    stream = '{
      8'hA5, 8'h01, 8'h00, 8'h00, 8'h03,
      8'h11, 8'h22, 8'h44, 8'h77,
      8'hA5, 8'h01, 8'h00, 8'h00, 8'h03,
      8'h11, 8'h22, 8'h44, 8'h00,
      8'hA5, 8'h0F, 8'hFF, 8'h00, 8'h02,
      8'hAA, 8'h55, 8'hFF,
      8'h00, 8'h13, 8'hA5, 8'h00, 8'h00,
      8'h00, 8'h00, 8'h00,
      8'hA5, 8'h00, 8'h10, 8'h00, 8'h02,
      8'hA5, 8'h5A, 8'hFF
    };
    exp_wr = '{
      20'h10011, 20'h10122, 20'h10244,
      20'h10011, 20'h10122, 20'h10244,
      20'hFFFAA, 20'h00055,
      20'h010A5, 20'h0115A
    };
    tbl[0] = '{0,  9, 0, 3, 1'b0};
    tbl[1] = '{9,  9, 3, 3, 1'b1};
    tbl[2] = '{18, 8, 6, 2, 1'b0};
    tbl[3] = '{26, 8, 8, 0, 1'b0};
    tbl[4] = '{34, 8, 8, 2, 1'b0};

    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    rst_n        = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int k = 0; k < 5; k++)
      run_vec(k);

    // Stall after the header until the idle limit fires.
    clr();
    send(SYNC_BYTE);
    for (int i = 1; i < HDR_BYTES; i++)
      send((i == 4) ? 8'h05 : 8'h00);
    bus.rx_valid = 1'b0;
    chk("to_busy", 32'(bus.busy), 1);
    wait_done(TO + 20);
    chk("to_done", done_n, 1);
    chk("to_err", 32'(last_err), 1);
    chk("to_no_write", wq.size(), 0);
    @(posedge clk);
    #1;
    chk("to_busy_low", 32'(bus.busy), 0);
    run_vec(0);

    // Reset right as the second data write is on the port.
    clr();
    send(8'hA5);
    send(8'h02);
    send(8'h00);
    send(8'h00);
    send(8'h04);
    send(8'h11);
    send(8'h22);
    bus.rx_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_reset_vals();
    clr();
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_no_write", wq.size(), 0);
    chk("rst_done_none", done_n, 0);
    chk("rst_busy_idle", 32'(bus.busy), 0);
    run_vec(0);

    chk("err_done_rules", viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_loader.md
# ram_loader

Byte-stream loader that writes a framed payload into the data RAM through its write port. It sits directly upstream of `d_ram`: the UART receiver feeds it bytes over a valid/ready handshake, and it drives `w_addr`/`w_en`/`din` of the RAM. It parses a fixed header (sync, start address, length) and checks a trailing XOR checksum. It reports completion and error status to the CPU status register.

## Interface
Parameters:
- `addr_width`, 12, RAM address width; must match `d_ram`.
- `data_width`, 8, RAM word width; the payload uses one byte per word.
- `sync_byte`, 8'hA5, frame start marker.
- `timeout_cycles`, 65535, maximum idle cycles between bytes inside a frame.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `rx_data`  in  8  byte from the UART receiver.
- `rx_valid`  in  1  `rx_data` is valid.
- `rx_ready`  out  1  loader accepts the byte this cycle.
- `w_addr`  out  addr_width  RAM write address.
- `w_en`  out  1  RAM write strobe.
- `din`  out  data_width  RAM write data.
- `busy`  out  1  a frame is in progress (high from sync acceptance until the done pulse).
- `done`  out  1  one-cycle pulse at frame end.
- `err`  out  1  valid with `done`: checksum mismatch or timeout.

## Operation
- Byte transfer: a byte is accepted when `rx_valid && rx_ready`.
- `rx_ready` is 1 in every state except RESP.
- Frame format: `sync_byte`, ADDR_H, ADDR_L, LEN_H, LEN_L, LEN data bytes, CHK.
  - Address and length are big-endian, 16 bits each.
  - Address bits at and above `addr_width` are ignored.
- States:
  - IDLE: waits for the sync byte. Any other byte is accepted and discarded.
  - ADDR_H, ADDR_L, LEN_H, LEN_L: one byte each.
  - DATA: one byte per accepted transfer.
  - CHK: takes the checksum byte.
  - RESP: lasts one cycle, then returns to IDLE.
- LEN_L transition: if LEN == 0, go to CHK; otherwise go to DATA.
- Each DATA byte:
  - One RAM write to the current address.
  - Address increments modulo 2^addr_width, so wrap from 0xFFF to 0x000 is legal.
  - Remaining count decrements.
  - Running XOR is updated.
  - After the last byte, go to CHK.
- Checksum: the running XOR of all data bytes only, cleared at sync. CHK compares the received byte to it.
- RESP: `done`=1, with `err` = mismatch.
- Timeout: in any state other than IDLE and RESP, an idle counter increments on each cycle with no accepted byte and clears on each accepted byte.
  - When the counter reaches `timeout_cycles`, go to RESP with `err`=1.
  - Writes already made are not undone.
- A sync byte received mid-frame is treated as ordinary data; there is no resynchronisation.
- Reset mid-frame: all state is discarded, the state goes to IDLE, and no write is issued in the cycle after reset.

## Timing
- Reset values: `rx_ready`=1, `w_en`=0, `w_addr`=0, `din`=0, `busy`=0, `done`=0, `err`=0. State is IDLE, counters are 0.
- All outputs are registered.
- Write latency: a DATA byte accepted at edge N produces `w_en`=1 with `w_addr`/`din` in the cycle after edge N, for exactly one cycle.
- The RAM write lands at edge N+1.
- Sustained throughput is one byte per cycle.
- `done`/`err` are asserted during the RESP cycle, which is the cycle after the CHK byte (or timeout) is accepted. `busy` drops in the same cycle.
- `err` is 0 whenever `done` is 0.
- The last data write and `done` never overlap, because CHK needs at least one more accepted byte.

## Structure
- Shared package `loader_pkg` holds:
  - the state enum (IDLE, ADDR_H, ADDR_L, LEN_H, LEN_L, DATA, CHK, RESP);
  - the `sync_byte` default;
  - the header byte count constant (5).
- Sub-module `ram_loader_timeout` is a natural split: a 16-bit idle counter with inputs clear and enable and an output `expired`.
- Everything else stays in one FSM module.

## Test plan
- Frame A5 01 00 00 03 11 22 44 77 → writes 0x11@0x100, 0x22@0x101, 0x44@0x102 on consecutive cycles; then `done`=1, `err`=0.
- Same frame with CHK=0x00 → same three writes; then `done`=1, `err`=1.
- Frame A5 0F FF 00 02 AA 55 FF → writes 0xAA@0xFFF, then 0x55@0x000 (wrap); `err`=0.
- Bytes 00 13 followed by a frame with LEN=0 and CHK=00 → garbage bytes are ignored, no writes occur, `done`=1, `err`=0.
- `rx_valid` drops for `timeout_cycles` after LEN_L → `done`=1, `err`=1, return to IDLE; a following valid frame loads correctly.
- `rst_n` asserted after the second data byte → all outputs return to their reset values, `w_en` stays 0; a fresh frame then loads correctly.
